ifetch_prefetch: RTL and testbench
==================================

// Module: ifetch_prefetch
// PURPOSE
//  Parametrised successor to the single-request instruction fetch unit.
//  - Keeps up to MAX_OUTSTANDING requests in flight on the inst sram-like bus.
//  - Buffers returned instructions with their PCs in a DEPTH-entry queue that feeds if_id.
//  - On a redirect (exception flush or branch), in-flight responses are dropped, not waited for.
//  - Misaligned fetch PCs are flagged as AdEL without a bus access.
// PARAMETERS
//  DEPTH            4             output queue entries; power of 2, >=2
//  MAX_OUTSTANDING  2             max accepted-but-unreturned requests; power of 2, <=DEPTH
//  RESET_PC         32'hbfc00000  fetch PC after reset
// PORTS
//  clk           in   1   clock; everything is rising-edge
//  rst           in   1   reset; synchronous, active-high
//  redirect      in   1   flush pipeline and refetch from redirect_pc
//  redirect_pc   in   32  new fetch PC
//  out_valid     out  1   queue head valid
//  out_ready     in   1   if_id accepts head (en_if_id)
//  out_pc        out  32  PC of head entry
//  out_inst      out  32  instruction of head entry (0 when out_adel)
//  out_adel      out  1   head entry is an address-error fetch
//  inst_req      out  1   sram-like request
//  inst_wr       out  1   constant 0
//  inst_size     out  2   constant 2'b10
//  inst_addr     out  32  = fetch_pc
//  inst_wdata    out  32  constant 0
//  inst_rdata    in   32  response data
//  inst_addr_ok  in   1   request accepted
//  inst_data_ok  in   1   response valid (in order)
// BEHAVIOUR
//  Reset (rst=1 at an edge)
//  - fetch_pc=RESET_PC; outstanding=0; discard=0; queue empty; pc fifo empty; adel_hold=0.
//  - During and after reset: out_valid=0, inst_req=0.
//  - The bus bridge is reset with the core; no stale responses are expected.
//  Issue
//  - inst_req = !rst & !adel_hold & fetch_pc[1:0]==0 & outstanding<MAX_OUTSTANDING
//    & (count+outstanding)<DEPTH.
//  - Accept = inst_req & inst_addr_ok.
//  - On accept: fetch_pc+=4 (32-bit wrap); outstanding++; push fetch_pc into pc fifo.
//  - inst_addr is stable while inst_req=1 and addr_ok=0, except that a redirect updates it.
//  Response (data_ok)
//  - Every data_ok: pop pc fifo; outstanding--.
//  - If discard!=0: discard--, entry dropped.
//  - Otherwise push {pc, inst_rdata, adel=0} into queue; out_valid rises the next cycle (1-cycle latency).
//  - Credit rule guarantees the queue is never full on a kept data_ok (assertion).
//  Misaligned PC
//  - If fetch_pc[1:0]!=0 and the queue is not full: push {fetch_pc, 0, adel=1}; set adel_hold.
//  - No bus request is made; issue stays stopped until the next redirect.
//  Output
//  - Pop on out_valid & out_ready.
//  - Head fields are registered queue outputs.
//  Redirect (highest priority, same cycle)
//  - Queue cleared; any pop or push that cycle is ignored.
//  - fetch_pc=redirect_pc; adel_hold=0.
//  - discard = outstanding + accept - data_ok, using this cycle's values.
//  - A request accepted in the redirect cycle is therefore discarded.
//  - A data_ok in the redirect cycle is dropped.
//  - Redirect with discard!=0: new responses are still dropped first (bus is in-order).
//  Counters
//  - outstanding and discard are $clog2(MAX_OUTSTANDING)+1 bits.
//  - count is $clog2(DEPTH)+1 bits; invariant discard<=outstanding.
// STRUCTURE
//  - Bus widths `InstAddrBus/`InstBus come from define.vh.
//  - Add `INST_SIZE_WORD (2'b10) to define.vh.
//  - Sub-module fifo_sync #(WIDTH,DEPTH): sync reset, push/pop/clear, full/empty/count.
//  - fifo_sync is instantiated twice: pc fifo (32b x MAX_OUTSTANDING) and output queue (65b x DEPTH).
// TESTING
//  1. Reset release, addr_ok=1, data_ok 1 cycle later, out_ready=1
//     -> PCs bfc00000, bfc00004, ... in order; 2 requests in flight.
//  2. out_ready=0, bus always ready
//     -> exactly 4 entries queued, inst_req=0.
//     Then ready=1 for 1 cycle -> one pop, one new request.
//  3. Redirect to 80001000 with 2 outstanding
//     -> next 2 data_ok dropped; first out_pc=80001000; no stale PC reaches out_valid.
//  4. Redirect in the same cycle as accept and data_ok
//     -> discard = outstanding; queue empty next cycle; first out_pc = redirect_pc.
//  5. Redirect to 80001002
//     -> no inst_req; one entry with out_adel=1, out_pc=80001002; fetch resumes after a redirect to aligned bfc00380.
//  6. rst asserted mid-burst with 2 outstanding
//     -> next cycle out_valid=0, inst_req=0, inst_addr=bfc00000 after release.

Source files
------------

// File: rtl/ifetch_prefetch_pkg.sv
// ifetch_prefetch_pkg
//   Shared widths, constants and the output-queue entry type for the
//   prefetching instruction fetch unit.
//   Contents:
//     INST_ADDR_W / INST_W  instruction bus address and data widths
//     INST_SIZE_WORD        sram-like size code for a 32-bit access
//     fetch_entry_t         {pc, inst, adel} record held in the output queue
//     pc_aligned()          word-alignment test for a fetch PC
package ifetch_prefetch_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;

  localparam logic [1:0] INST_SIZE_WORD = 2'b10;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
    logic                   adel;
  } fetch_entry_t;

  function automatic logic pc_aligned(input logic [INST_ADDR_W-1:0] pc);
    return pc[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/ifetch_prefetch_if.sv
// ifetch_prefetch_if
//   Instruction-side sram-like bus.
//   Signals:
//     inst_req      request valid (master)
//     inst_wr       write flag, always 0 for fetch (master)
//     inst_size     access size code (master)
//     inst_addr     request address (master)
//     inst_wdata    write data, unused for fetch (master)
//     inst_rdata    response data (slave)
//     inst_addr_ok  request accepted this cycle (slave)
//     inst_data_ok  in-order response valid this cycle (slave)
//   Modports: master = fetch unit, slave = memory / bus bridge.
interface ifetch_prefetch_if;
  import ifetch_prefetch_pkg::*;

  logic                   inst_req;
  logic                   inst_wr;
  logic [1:0]             inst_size;
  logic [INST_ADDR_W-1:0] inst_addr;
  logic [INST_W-1:0]      inst_wdata;
  logic [INST_W-1:0]      inst_rdata;
  logic                   inst_addr_ok;
  logic                   inst_data_ok;

  modport master (
    output inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
    input  inst_rdata, inst_addr_ok, inst_data_ok
  );

  modport slave (
    input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
    output inst_rdata, inst_addr_ok, inst_data_ok
  );

endinterface

// File: rtl/ifetch_prefetch_fifo_sync.sv
// fifo_sync
//   Synchronous FIFO with registered storage, used for both the in-flight
//   PC tracker and the fetch output queue.
//   Ports:
//     clk, rst   rising-edge clock, synchronous active-high reset
//     push_i     write din_i (ignored when full unless a pop frees a slot)
//     pop_i      drop the head entry (ignored when empty)
//     clear_i    empty the FIFO; overrides push/pop in the same cycle
//     din_i      write data
//     dout_o     head entry (valid when !empty_o)
//     full_o     DEPTH entries held
//     empty_o    no entries held
//     count_o    number of entries held, 0..DEPTH
module fifo_sync #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     clear_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, wr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];

  assign do_pop  = pop_i & ~empty_o;
  // A pop frees the slot the push lands in, so push is legal even when full.
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= ptr_next(wr_q);
      if (do_pop)  rd_q <= ptr_next(rd_q);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !clear_i && do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/ifetch_prefetch.sv
// ifetch_prefetch
//   Prefetching instruction fetch unit: keeps up to MAX_OUTSTANDING requests
//   in flight on the inst sram-like bus, queues returned instructions with
//   their PCs in a DEPTH-entry queue feeding if_id, drops in-flight responses
//   after a redirect, and flags misaligned fetch PCs as AdEL without a bus
//   access.
//   Ports:
//     clk, rst      rising-edge clock, synchronous active-high reset
//     redirect      flush and refetch from redirect_pc (highest priority)
//     redirect_pc   new fetch PC
//     out_valid     queue head valid
//     out_ready     if_id accepts the head
//     out_pc        PC of head entry
//     out_inst      instruction of head entry (0 for AdEL entries)
//     out_adel      head entry is an address-error fetch
//     inst          inst sram-like bus (master side)
module ifetch_prefetch
  import ifetch_prefetch_pkg::*;
#(
  parameter int unsigned            DEPTH           = 4,
  parameter int unsigned            MAX_OUTSTANDING = 2,
  parameter logic [INST_ADDR_W-1:0] RESET_PC        = 32'hbfc00000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect,
  input  logic [INST_ADDR_W-1:0] redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INST_ADDR_W-1:0] out_pc,
  output logic [INST_W-1:0]      out_inst,
  output logic                   out_adel,
  ifetch_prefetch_if.master      inst
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [INST_ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [OW-1:0]          discard_q, discard_d;
  logic                   adel_hold_q, adel_hold_d;

  // In-flight PC tracker; its occupancy is the outstanding-request count.
  logic [INST_ADDR_W-1:0] pcf_dout;
  logic                   pcf_full, pcf_empty;
  logic [OW-1:0]          outstanding;

  fetch_entry_t           q_din, q_dout;
  logic                   q_push, q_pop, q_full, q_empty;
  logic [CW-1:0]          q_count;

  logic                   issue, accept, rsp, kept, adel_push;
  logic [CW:0]            credit;

  // Queue slots already promised = held entries + requests still in flight.
  // Keeping that below DEPTH means a kept response always finds room.
  assign credit = (CW+1)'(q_count) + (CW+1)'(outstanding);

  assign issue  = ~rst & ~adel_hold_q & pc_aligned(fetch_pc_q) & ~pcf_full
                & (credit < (CW+1)'(DEPTH));
  assign accept = issue & inst.inst_addr_ok;
  // A response with nothing tracked in flight is spurious and ignored.
  assign rsp    = inst.inst_data_ok & ~pcf_empty;
  assign kept   = rsp & (discard_q == '0) & ~redirect;

  assign adel_push = ~redirect & ~adel_hold_q & ~pc_aligned(fetch_pc_q) & ~q_full;

  assign inst.inst_req   = issue;
  assign inst.inst_wr    = 1'b0;
  assign inst.inst_size  = INST_SIZE_WORD;
  assign inst.inst_addr  = fetch_pc_q;
  assign inst.inst_wdata = '0;

  fifo_sync #(
    .WIDTH (INST_ADDR_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pc_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept),
    .pop_i   (rsp),
    .clear_i (1'b0),
    .din_i   (fetch_pc_q),
    .dout_o  (pcf_dout),
    .full_o  (pcf_full),
    .empty_o (pcf_empty),
    .count_o (outstanding)
  );

  always_comb begin
    q_din = '0;
    if (kept) begin
      q_din.pc   = pcf_dout;
      q_din.inst = inst.inst_rdata;
      q_din.adel = 1'b0;
    end else begin
      q_din.pc   = fetch_pc_q;
      q_din.inst = '0;
      q_din.adel = 1'b1;
    end
  end

  assign q_push = kept | adel_push;
  assign q_pop  = out_valid & out_ready & ~redirect;

  fifo_sync #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_out_queue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (q_push),
    .pop_i   (q_pop),
    .clear_i (redirect),
    .din_i   (q_din),
    .dout_o  (q_dout),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_count)
  );

  assign out_valid = ~rst & ~q_empty;
  assign out_pc    = q_dout.pc;
  assign out_inst  = q_dout.inst;
  assign out_adel  = q_dout.adel;

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    adel_hold_d = adel_hold_q;
    discard_d   = discard_q;
    if (accept)                    fetch_pc_d  = fetch_pc_q + 32'd4;
    if (adel_push)                 adel_hold_d = 1'b1;
    if (rsp && discard_q != '0)    discard_d   = discard_q - OW'(1);
    if (redirect) begin
      fetch_pc_d  = redirect_pc;
      adel_hold_d = 1'b0;
      // Everything still in flight after this edge belongs to the old path,
      // including a request accepted in this very cycle.
      discard_d   = outstanding + OW'(accept) - OW'(rsp);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q  <= RESET_PC;
      discard_q   <= '0;
      adel_hold_q <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      discard_q   <= discard_d;
      adel_hold_q <= adel_hold_d;
    end
  end

  a_kept_has_room: assert property (@(posedge clk) disable iff (rst) kept |-> !q_full);
  a_discard_le_out: assert property (@(posedge clk) disable iff (rst) discard_q <= outstanding);

endmodule

// File: tb/tb_ifetch_prefetch.sv
module tb_ifetch_prefetch;
  import ifetch_prefetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst, redirect, out_ready, out_valid, out_adel;
  logic [31:0] redirect_pc, out_pc, out_inst;

  always #5 clk = ~clk;

  ifetch_prefetch_if bus ();

  ifetch_prefetch #(
    .DEPTH           (4),
    .MAX_OUTSTANDING (2),
    .RESET_PC        (32'hbfc00000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_inst    (out_inst),
    .out_adel    (out_adel),
    .inst        (bus)
  );

  int          checks = 0;
  int          failures = 0;
  int          accepts;
  logic        resp_en;
  logic [31:0] pend[$];
  logic [64:0] got[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5a5a0f0f;
  endfunction

  function automatic logic [64:0] entry(input logic [31:0] pc, input logic [31:0] ins, input logic adel);
    return {pc, ins, adel};
  endfunction

  function automatic logic [64:0] got_at(input int i);
    if (i < got.size()) return got[i];
    return 'x;
  endfunction

  // One clock: sample the bus and queue head mid-cycle, then advance the
  // in-order memory model (responses 1 cycle after accept when resp_en=1).
  task automatic tick();
    logic        acc, dok, rst_s;
    logic [31:0] a;
    @(negedge clk);
    acc   = bus.inst_req & bus.inst_addr_ok;
    dok   = bus.inst_data_ok;
    a     = bus.inst_addr;
    rst_s = rst;
    if (out_valid && out_ready && !redirect) got.push_back({out_pc, out_inst, out_adel});
    @(posedge clk);
    #1;
    if (rst_s) begin
      pend.delete();
    end else begin
      if (dok && pend.size() > 0) void'(pend.pop_front());
      if (acc) begin
        pend.push_back(a);
        accepts++;
      end
    end
    bus.inst_data_ok = resp_en && (pend.size() > 0);
    bus.inst_rdata   = '0;
    if (bus.inst_data_ok) bus.inst_rdata = mem_word(pend[0]);
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    bus.inst_addr_ok = 1'b0; resp_en = 1'b0;
    tick(); tick();
    rst = 1'b0;
    got.delete();
    accepts = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    bus.inst_addr_ok = 1'b1; resp_en = 1'b1;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (bus.inst_req !== 1'b0) begin failures++; $display("FAIL reset_inst_req got=%b exp=0", bus.inst_req); end
    rst = 1'b0; bus.inst_addr_ok = 1'b0;
    #1;
    checks++; if (bus.inst_addr !== 32'hbfc00000) begin failures++; $display("FAIL reset_addr got=%h exp=bfc00000", bus.inst_addr); end
    checks++; if (bus.inst_req !== 1'b1) begin failures++; $display("FAIL reset_release_req got=%b exp=1", bus.inst_req); end
    checks++; if (bus.inst_wr !== 1'b0 || bus.inst_size !== 2'b10 || bus.inst_wdata !== 32'h0) begin
      failures++; $display("FAIL const_fields got wr=%b size=%b wdata=%h exp wr=0 size=10 wdata=0", bus.inst_wr, bus.inst_size, bus.inst_wdata);
    end
    tick(); tick();
    checks++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hbfc00000) begin
      failures++; $display("FAIL addr_stable got req=%b addr=%h exp req=1 addr=bfc00000", bus.inst_req, bus.inst_addr);
    end
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1; bus.inst_addr_ok = 1'b1; resp_en = 1'b1;
    repeat (12) tick();
    for (int i = 0; i < 8; i++) begin
      logic [31:0] pc;
      pc = 32'hbfc00000 + 32'(4 * i);
      checks++;
      if (got_at(i) !== entry(pc, mem_word(pc), 1'b0)) begin
        failures++; $display("FAIL stream_entry%0d got=%h exp=%h", i, got_at(i), entry(pc, mem_word(pc), 1'b0));
      end
    end
    resp_en = 1'b0;
    repeat (4) tick();
    checks++; if (pend.size() != 2) begin failures++; $display("FAIL max_outstanding got=%0d exp=2", pend.size()); end
    checks++; if (bus.inst_req !== 1'b0) begin failures++; $display("FAIL max_out_req got=%b exp=0", bus.inst_req); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0; bus.inst_addr_ok = 1'b1; resp_en = 1'b1;
    repeat (8) tick();
    checks++; if (accepts != 4) begin failures++; $display("FAIL bp_accepts got=%0d exp=4", accepts); end
    checks++; if (bus.inst_req !== 1'b0) begin failures++; $display("FAIL bp_req_full got=%b exp=0", bus.inst_req); end
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'hbfc00000) begin
      failures++; $display("FAIL bp_head got valid=%b pc=%h exp valid=1 pc=bfc00000", out_valid, out_pc);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (got.size() != 1 || got_at(0) !== entry(32'hbfc00000, mem_word(32'hbfc00000), 1'b0)) begin
      failures++; $display("FAIL bp_one_pop got n=%0d e0=%h exp n=1", got.size(), got_at(0));
    end
    checks++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hbfc00010) begin
      failures++; $display("FAIL bp_new_req got req=%b addr=%h exp req=1 addr=bfc00010", bus.inst_req, bus.inst_addr);
    end
    tick(); tick();
    checks++; if (accepts != 5 || bus.inst_req !== 1'b0) begin
      failures++; $display("FAIL bp_refill got accepts=%0d req=%b exp accepts=5 req=0", accepts, bus.inst_req);
    end
    checks++; if (out_pc !== 32'hbfc00004) begin failures++; $display("FAIL bp_next_head got=%h exp=bfc00004", out_pc); end
  endtask

  task automatic test_redirect_outstanding();
    int stale;
    do_reset();
    out_ready = 1'b1; bus.inst_addr_ok = 1'b1; resp_en = 1'b0;
    repeat (3) tick();
    checks++; if (pend.size() != 2) begin failures++; $display("FAIL rd_inflight got=%0d exp=2", pend.size()); end
    redirect = 1'b1; redirect_pc = 32'h80001000;
    tick();
    redirect = 1'b0; resp_en = 1'b1;
    repeat (10) tick();
    checks++; if (got_at(0) !== entry(32'h80001000, mem_word(32'h80001000), 1'b0)) begin
      failures++; $display("FAIL rd_first got=%h exp=%h", got_at(0), entry(32'h80001000, mem_word(32'h80001000), 1'b0));
    end
    checks++; if (got_at(1) !== entry(32'h80001004, mem_word(32'h80001004), 1'b0)) begin
      failures++; $display("FAIL rd_second got=%h exp=%h", got_at(1), entry(32'h80001004, mem_word(32'h80001004), 1'b0));
    end
    stale = 0;
    foreach (got[i]) if (got[i][64:61] == 4'hb) stale++;
    checks++; if (stale != 0) begin failures++; $display("FAIL rd_stale got=%0d exp=0", stale); end
  endtask

  task automatic test_redirect_same_cycle();
    do_reset();
    out_ready = 1'b0; bus.inst_addr_ok = 1'b1; resp_en = 1'b1;
    repeat (3) tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL sc_pre_valid got=%b exp=1", out_valid); end
    checks++; if (bus.inst_req !== 1'b1 || bus.inst_data_ok !== 1'b1) begin
      failures++; $display("FAIL sc_setup got req=%b dok=%b exp req=1 dok=1", bus.inst_req, bus.inst_data_ok);
    end
    redirect = 1'b1; redirect_pc = 32'h80002000;
    tick();
    redirect = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL sc_cleared got=%b exp=0", out_valid); end
    out_ready = 1'b1;
    repeat (8) tick();
    checks++; if (got_at(0) !== entry(32'h80002000, mem_word(32'h80002000), 1'b0)) begin
      failures++; $display("FAIL sc_first got=%h exp=%h", got_at(0), entry(32'h80002000, mem_word(32'h80002000), 1'b0));
    end
    checks++; if (got_at(1) !== entry(32'h80002004, mem_word(32'h80002004), 1'b0)) begin
      failures++; $display("FAIL sc_second got=%h exp=%h", got_at(1), entry(32'h80002004, mem_word(32'h80002004), 1'b0));
    end
  endtask

  task automatic test_misaligned();
    int req_seen;
    do_reset();
    out_ready = 1'b1; bus.inst_addr_ok = 1'b1; resp_en = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h80001002;
    tick();
    redirect = 1'b0;
    req_seen = 0;
    repeat (6) begin
      tick();
      if (bus.inst_req !== 1'b0) req_seen++;
    end
    checks++; if (req_seen != 0) begin failures++; $display("FAIL adel_no_req got=%0d exp=0", req_seen); end
    checks++; if (got.size() != 1) begin failures++; $display("FAIL adel_count got=%0d exp=1", got.size()); end
    checks++; if (got_at(0) !== entry(32'h80001002, 32'h0, 1'b1)) begin
      failures++; $display("FAIL adel_entry got=%h exp=%h", got_at(0), entry(32'h80001002, 32'h0, 1'b1));
    end
    redirect = 1'b1; redirect_pc = 32'hbfc00380;
    tick();
    redirect = 1'b0;
    checks++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hbfc00380) begin
      failures++; $display("FAIL adel_resume_req got req=%b addr=%h exp req=1 addr=bfc00380", bus.inst_req, bus.inst_addr);
    end
    repeat (5) tick();
    checks++; if (got_at(1) !== entry(32'hbfc00380, mem_word(32'hbfc00380), 1'b0)) begin
      failures++; $display("FAIL adel_resume got=%h exp=%h", got_at(1), entry(32'hbfc00380, mem_word(32'hbfc00380), 1'b0));
    end
  endtask

  task automatic test_reset_midburst();
    do_reset();
    out_ready = 1'b0; bus.inst_addr_ok = 1'b1; resp_en = 1'b1;
    tick(); tick();
    resp_en = 1'b0;
    tick(); tick();
    checks++; if (out_valid !== 1'b1 || pend.size() != 2) begin
      failures++; $display("FAIL mid_pre got valid=%b inflight=%0d exp valid=1 inflight=2", out_valid, pend.size());
    end
    rst = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", out_valid); end
    checks++; if (bus.inst_req !== 1'b0) begin failures++; $display("FAIL mid_rst_req got=%b exp=0", bus.inst_req); end
    rst = 1'b0;
    #1;
    checks++; if (bus.inst_addr !== 32'hbfc00000 || bus.inst_req !== 1'b1) begin
      failures++; $display("FAIL mid_release got req=%b addr=%h exp req=1 addr=bfc00000", bus.inst_req, bus.inst_addr);
    end
    out_ready = 1'b1; resp_en = 1'b1;
    got.delete();
    repeat (5) tick();
    checks++; if (got_at(0) !== entry(32'hbfc00000, mem_word(32'hbfc00000), 1'b0)) begin
      failures++; $display("FAIL mid_first got=%h exp=%h", got_at(0), entry(32'hbfc00000, mem_word(32'hbfc00000), 1'b0));
    end
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = '0;
    resp_en = 1'b0; accepts = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_outstanding();
    test_redirect_same_cycle();
    test_misaligned();
    test_reset_midburst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
